// File: rtl/hero_write_collector_pkg.sv
// Shared hero bus types plus the framed-beat types used by the write collector.
//   hero_write_t         : raw per-cycle hero write bus beat (46 bits)
//   hero_beat_t          : buffered/framed beat (wdat, sub, idx, last, abort)
//   HERO_COLLECT_STATE_E : collector FSM states
package hero_write_collector_pkg;

    localparam int HERO_WDAT_WIDTH     = 36;
    localparam int SUB_DEF_WIDTH       = 7;
    localparam int HERO_CYCLE_WIDTH    = 2;
    localparam int HERO_WRITE_WIDTH    = 1 + HERO_CYCLE_WIDTH + HERO_WDAT_WIDTH + SUB_DEF_WIDTH;

    localparam int HERO_MAX_BEATS      = 16;
    localparam int HERO_BEAT_IDX_WIDTH = $clog2(HERO_MAX_BEATS);
    localparam int HERO_BEAT_WIDTH     = HERO_WDAT_WIDTH + SUB_DEF_WIDTH + HERO_BEAT_IDX_WIDTH + 2;

    typedef logic [SUB_DEF_WIDTH-1:0] sub_def_t;

    // Encoding 0 is not a defined bus cycle and is treated as a no-op.
    typedef enum logic [HERO_CYCLE_WIDTH-1:0] {
        CYC_NOP   = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2,
        CYC_IDLE  = 2'd3
    } hero_cycle_e;

    typedef struct packed {
        logic                       clk_en;
        hero_cycle_e                cycle_type;
        logic [HERO_WDAT_WIDTH-1:0] wdat;
        sub_def_t                   sub;
    } hero_write_t;

    typedef struct packed {
        logic [HERO_WDAT_WIDTH-1:0]     wdat;
        sub_def_t                       sub;
        logic [HERO_BEAT_IDX_WIDTH-1:0] idx;
        logic                           last;
        logic                           abort;
    } hero_beat_t;

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } HERO_COLLECT_STATE_E;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hero_sync_fifo.sv
// Single-clock FIFO of a generic packed type.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   i_push/i_din : write request and data; ignored when full unless popping
//   i_pop        : read request; ignored when empty
//   o_dout       : head entry (valid while !o_empty)
//   o_full/o_empty/o_count : status derived from the registered count
module hero_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  T              i_din,
    input  logic          i_pop,
    output T              o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hero_write_collector.sv
// Collects hero write bus beats into framed valid/ready beats.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_write     : hero bus beat, sampled every cycle (no backpressure)
//   out_valid/out_ready : output handshake
//   out_wdat, out_sub, out_idx, out_last, out_abort : framed beat
//   err_overflow : sticky, a live beat met a full FIFO
//   err_length   : sticky, a transaction exceeded MAX_BEATS
//   drop_cnt     : saturating count of discarded live beats
//
// state | meaning
// ------+-------------------------------------------------------------
// OPEN  | between transactions; next live beat is idx 0
// BURST | inside a transaction; r_idx holds the last pushed idx
// DROP  | discarding; may still owe an abort beat (r_abort_pend) and
//       | waits for the transaction's DONE (r_done_seen) before leaving
//
// Index widths follow the package (HERO_BEAT_IDX_WIDTH); MAX_BEATS only
// sets the length limit and is expected to match HERO_MAX_BEATS.
module hero_write_collector
    import hero_write_collector_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  MAX_BEATS = HERO_MAX_BEATS,
    localparam int IDXW      = HERO_BEAT_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  hero_write_t                in_write,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HERO_WDAT_WIDTH-1:0] out_wdat,
    output sub_def_t                   out_sub,
    output logic [IDXW-1:0]            out_idx,
    output logic                       out_last,
    output logic                       out_abort,
    output logic                       err_overflow,
    output logic                       err_length,
    output logic [15:0]                drop_cnt
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(MAX_BEATS - 1);

    HERO_COLLECT_STATE_E r_state;
    logic [IDXW-1:0]     r_idx;
    logic                r_abort_pend;
    logic                r_done_seen;
    logic                r_err_overflow;
    logic                r_err_length;
    logic [15:0]         r_drop_cnt;

    HERO_COLLECT_STATE_E w_state_nxt;
    logic [IDXW-1:0]     w_idx_nxt;
    logic [IDXW-1:0]     w_idx_inc;
    logic                w_abort_pend_nxt;
    logic                w_done_seen_nxt;
    logic                w_set_ovf;
    logic                w_set_len;
    logic                w_drop;
    logic                w_push;
    hero_beat_t          w_push_beat;

    hero_beat_t          w_head;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_pop;
    logic                w_space;
    logic                w_live;
    logic                w_is_done;

    assign w_live    = in_write.clk_en &&
                       (in_write.cycle_type == CYC_VALID || in_write.cycle_type == CYC_DONE);
    assign w_is_done = (in_write.cycle_type == CYC_DONE);
    assign w_pop     = out_valid & out_ready;
    assign w_space   = ~w_full | w_pop;
    assign w_idx_inc = r_idx + 1'b1;

    hero_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (hero_beat_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_beat),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FIFO storage is not reset, so the data outputs are forced to 0 when empty.
    assign out_valid    = (w_count != '0);
    assign out_wdat     = w_empty ? '0 : w_head.wdat;
    assign out_sub      = w_empty ? '0 : w_head.sub;
    assign out_idx      = w_empty ? '0 : w_head.idx;
    assign out_last     = w_empty ? 1'b0 : w_head.last;
    assign out_abort    = w_empty ? 1'b0 : w_head.abort;
    assign err_overflow = r_err_overflow;
    assign err_length   = r_err_length;
    assign drop_cnt     = r_drop_cnt;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_abort_pend_nxt = r_abort_pend;
        w_done_seen_nxt  = r_done_seen;
        w_set_ovf        = 1'b0;
        w_set_len        = 1'b0;
        w_drop           = 1'b0;
        w_push           = 1'b0;
        w_push_beat      = '0;

        case (r_state)
            OPEN: begin
                if (w_live) begin
                    if (w_space) begin
                        w_push           = 1'b1;
                        w_push_beat.wdat = in_write.wdat;
                        w_push_beat.sub  = in_write.sub;
                        w_push_beat.last = w_is_done;
                        w_idx_nxt        = '0;
                        if (!w_is_done) w_state_nxt = BURST;
                    end else begin
                        // Nothing was pushed for this transaction, so no abort is owed.
                        w_drop           = 1'b1;
                        w_set_ovf        = 1'b1;
                        w_abort_pend_nxt = 1'b0;
                        w_done_seen_nxt  = w_is_done;
                        w_state_nxt      = DROP;
                    end
                end
            end

            BURST: begin
                if (w_live) begin
                    if (w_space) begin
                        w_push           = 1'b1;
                        w_push_beat.wdat = in_write.wdat;
                        w_push_beat.sub  = in_write.sub;
                        w_push_beat.idx  = w_idx_inc;
                        w_idx_nxt        = w_idx_inc;
                        if (w_is_done) begin
                            w_push_beat.last = 1'b1;
                            w_state_nxt      = OPEN;
                        end else if (w_idx_inc == IDX_MAX) begin
                            // The truncating beat itself carries the abort.
                            w_push_beat.last  = 1'b1;
                            w_push_beat.abort = 1'b1;
                            w_set_len         = 1'b1;
                            w_abort_pend_nxt  = 1'b0;
                            w_done_seen_nxt   = 1'b0;
                            w_state_nxt       = DROP;
                        end
                    end else begin
                        w_drop           = 1'b1;
                        w_set_ovf        = 1'b1;
                        w_abort_pend_nxt = 1'b1;
                        w_done_seen_nxt  = w_is_done;
                        w_state_nxt      = DROP;
                    end
                end
            end

            DROP: begin
                if (w_live) begin
                    w_drop = 1'b1;
                    if (w_is_done) w_done_seen_nxt = 1'b1;
                end
                if (r_abort_pend && w_space) begin
                    w_push            = 1'b1;
                    w_push_beat.idx   = (r_idx == IDX_MAX) ? IDX_MAX : w_idx_inc;
                    w_push_beat.last  = 1'b1;
                    w_push_beat.abort = 1'b1;
                    w_abort_pend_nxt  = 1'b0;
                end
                // Registered flags: exit lands one cycle after the later event.
                if (r_done_seen && !r_abort_pend) begin
                    w_done_seen_nxt = 1'b0;
                    w_state_nxt     = OPEN;
                end
            end

            default: begin
                w_state_nxt = OPEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= OPEN;
            r_idx          <= '0;
            r_abort_pend   <= 1'b0;
            r_done_seen    <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_length   <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_abort_pend   <= w_abort_pend_nxt;
            r_done_seen    <= w_done_seen_nxt;
            r_err_overflow <= r_err_overflow | w_set_ovf;
            r_err_length   <= r_err_length | w_set_len;
            if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
        end
    end

endmodule

// File: tb/tb_hero_write_collector.sv
module tb_hero_write_collector;
    import hero_write_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    hero_write_t in_write;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_wdat;
    sub_def_t    out_sub;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_abort;
    logic        err_overflow;
    logic        err_length;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [35:0] wdat;
        logic [6:0]  sub;
        logic [3:0]  idx;
        logic        last;
        logic        abort;
        int          cyc;
    } rec_t;

    rec_t q[$];

    hero_write_collector #(.DEPTH(8), .MAX_BEATS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_write     (in_write),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wdat     (out_wdat),
        .out_sub      (out_sub),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_abort    (out_abort),
        .err_overflow (err_overflow),
        .err_length   (err_length),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each beat that will transfer on the coming edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            q.push_back('{out_wdat, out_sub, out_idx, out_last, out_abort, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input hero_cycle_e ct, input logic en, input logic [35:0] wd, input logic [6:0] sb);
        in_write.clk_en     = en;
        in_write.cycle_type = ct;
        in_write.wdat       = wd;
        in_write.sub        = sb;
        tick();
    endtask

    task automatic nop();
        drive(CYC_VALID, 1'b0, 36'h0, 7'h0);
    endtask

    task automatic drain(input int n, input int budget, input string name);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_vec++;
        if (q.size() != n) begin
            n_err++;
            $display("FAIL %s beat_count got=%0d exp=%0d", name, q.size(), n);
        end
    endtask

    task automatic check_beat(input string name, input int i, input logic [35:0] wd, input logic [6:0] sb,
                              input logic [3:0] ix, input logic ls, input logic ab);
        logic [49:0] got, exp;
        if (i < q.size()) begin
            got = {q[i].wdat, q[i].sub, q[i].idx, q[i].last, q[i].abort};
            exp = {wd, sb, ix, ls, ab};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s beat%0d {wdat,sub,idx,last,abort} got=%h exp=%h", name, i, got, exp);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if ({out_valid, out_wdat, out_sub, out_idx, out_last, out_abort} !== '0) begin
            n_err++;
            $display("FAIL %s outputs got v=%b wdat=%h sub=%h idx=%h last=%b abort=%b exp all 0",
                     name, out_valid, out_wdat, out_sub, out_idx, out_last, out_abort);
        end
        n_vec++;
        if ({err_overflow, err_length, drop_cnt} !== 18'h0) begin
            n_err++;
            $display("FAIL %s errors got ovf=%b len=%b drop=%0d exp 0 0 0",
                     name, err_overflow, err_length, drop_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        in_write  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("reset");
    endtask

    task automatic test_single_txn();
        int t0;
        q.delete();
        out_ready = 1'b1;
        t0 = cyc;
        drive(CYC_VALID, 1'b1, 36'h1, 7'h11);
        drive(CYC_VALID, 1'b1, 36'h2, 7'h12);
        drive(CYC_VALID, 1'b1, 36'h3, 7'h13);
        drive(CYC_DONE,  1'b1, 36'h4, 7'h14);
        nop();
        drain(4, 20, "single_txn");
        for (int i = 0; i < 4; i++) begin
            check_beat("single_txn", i, 36'(i + 1), 7'(8'h11 + i), 4'(i), (i == 3), 1'b0);
            if (i < q.size()) begin
                n_vec++;
                if (q[i].cyc != t0 + 1 + i) begin
                    n_err++;
                    $display("FAIL single_txn timing beat%0d got_cyc=%0d exp_cyc=%0d", i, q[i].cyc, t0 + 1 + i);
                end
            end
        end
        n_vec++;
        if ({err_overflow, err_length, drop_cnt} !== 18'h0) begin
            n_err++;
            $display("FAIL single_txn errors got ovf=%b len=%b drop=%0d exp 0", err_overflow, err_length, drop_cnt);
        end
    endtask

    task automatic test_single_done();
        q.delete();
        drive(CYC_DONE, 1'b1, 36'hAB, 7'h05);
        nop();
        drive(CYC_IDLE, 1'b1, 36'h55, 7'h06);
        drain(1, 20, "single_done");
        check_beat("single_done", 0, 36'hAB, 7'h05, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(CYC_VALID, 1'b1, 36'h100 + 36'(i), 7'(i));
        drive(CYC_DONE, 1'b1, 36'h1FF, 7'h7F);
        nop();
        nop();
        n_vec++;
        if ({out_valid, out_wdat, out_idx} !== {1'b1, 36'h100, 4'd0}) begin
            n_err++;
            $display("FAIL backpressure stalled_head got v=%b wdat=%h idx=%0d exp v=1 wdat=100 idx=0",
                     out_valid, out_wdat, out_idx);
        end
        n_vec++;
        if ({err_overflow, drop_cnt} !== {1'b1, 16'd3}) begin
            n_err++;
            $display("FAIL backpressure errors got ovf=%b drop=%0d exp ovf=1 drop=3", err_overflow, drop_cnt);
        end
        out_ready = 1'b1;
        drain(9, 40, "backpressure");
        for (int i = 0; i < 8; i++)
            check_beat("backpressure", i, 36'h100 + 36'(i), 7'(i), 4'(i), 1'b0, 1'b0);
        check_beat("backpressure_abort", 8, 36'h0, 7'h0, 4'd8, 1'b1, 1'b1);
        n_vec++;
        if (drop_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL backpressure drop_after got=%0d exp=3", drop_cnt);
        end
    endtask

    task automatic test_overlength();
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) drive(CYC_VALID, 1'b1, 36'h200 + 36'(i), 7'h20);
        drive(CYC_DONE, 1'b1, 36'h2FF, 7'h21);
        nop();
        drive(CYC_VALID, 1'b1, 36'h300, 7'h30);
        drive(CYC_DONE,  1'b1, 36'h301, 7'h31);
        nop();
        drain(18, 60, "overlength");
        for (int i = 0; i < 16; i++)
            check_beat("overlength", i, 36'h200 + 36'(i), 7'h20, 4'(i), (i == 15), (i == 15));
        check_beat("overlength_next", 16, 36'h300, 7'h30, 4'd0, 1'b0, 1'b0);
        check_beat("overlength_next", 17, 36'h301, 7'h31, 4'd1, 1'b1, 1'b0);
        n_vec++;
        if ({err_length, drop_cnt} !== {1'b1, 16'd8}) begin
            n_err++;
            $display("FAIL overlength errors got len=%b drop=%0d exp len=1 drop=8 (3 earlier + 5)", err_length, drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(CYC_VALID, 1'b1, 36'h400 + 36'(i), 7'h40);
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            drive(CYC_VALID, 1'b1, 36'h408 + 36'(k), 7'h40);
            out_ready = 1'b0;
            nop();
        end
        out_ready = 1'b1;
        drive(CYC_DONE, 1'b1, 36'h40E, 7'h41);
        nop();
        drain(15, 60, "full_pop");
        for (int i = 0; i < 15; i++)
            check_beat("full_pop", i, 36'h400 + 36'(i), (i == 14) ? 7'h41 : 7'h40, 4'(i), (i == 14), 1'b0);
        n_vec++;
        if (drop_cnt !== 16'd8) begin
            n_err++;
            $display("FAIL full_pop drop_cnt got=%0d exp=8", drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        out_ready = 1'b0;
        drive(CYC_VALID, 1'b1, 36'h500, 7'h50);
        drive(CYC_VALID, 1'b1, 36'h501, 7'h50);
        drive(CYC_VALID, 1'b1, 36'h502, 7'h50);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid queued got valid=%b exp=1", out_valid);
        end
        rst_n = 1'b0;
        nop();
        check_idle_outputs("reset_mid");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(CYC_VALID, 1'b1, 36'h600, 7'h60);
        drive(CYC_DONE,  1'b1, 36'h601, 7'h61);
        nop();
        drain(2, 20, "reset_mid");
        check_beat("reset_mid", 0, 36'h600, 7'h60, 4'd0, 1'b0, 1'b0);
        check_beat("reset_mid", 1, 36'h601, 7'h61, 4'd1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_txn();
        test_single_done();
        test_backpressure();
        test_overlength();
        test_full_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hero_write_collector.md
# hero_write_collector

Sits directly downstream of the hero write bus and turns its per-cycle `hero_write_t` beats into framed, flow-controlled beats. The hero bus has no backpressure. This block therefore buffers beats in a small FIFO, numbers each beat within its transaction, and marks the last beat of each transaction. It presents the result on a valid/ready interface. Overflow and over-length transactions are closed with an abort beat, so downstream framing is never left open.

## Interface
- `DEPTH`, 8: FIFO entries; power of 2, ≥2.
- `MAX_BEATS`, 16: maximum beats per transaction; power of 2. `IDXW = clog2(MAX_BEATS)`.
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_write` in 46 (`hero_write_t`): hero bus, sampled every cycle.
- `out_valid` out 1: an output beat is available.
- `out_ready` in 1: downstream accepts the beat.
- `out_wdat` out 36: beat data.
- `out_sub` out 7 (`sub_def_t`): beat sideband.
- `out_idx` out IDXW: beat number within the transaction, starting at 0.
- `out_last` out 1: final beat of the transaction.
- `out_abort` out 1: the transaction was truncated; qualifies the last beat.
- `err_overflow` out 1: sticky; a beat arrived while the FIFO was full.
- `err_length` out 1: sticky; a transaction exceeded MAX_BEATS.
- `drop_cnt` out 16: saturating count of dropped beats.

## Operation
- A live beat is `clk_en==1` with `cycle_type` equal to VALID or DONE. IDLE, encoding 3, or `clk_en==0` is a no-op.
- FSM states:
  - OPEN: between transactions; reset state.
  - BURST: inside a transaction.
  - DROP: discarding the rest of a transaction.
- Transitions from OPEN:
  - VALID: push idx 0, go to BURST.
  - DONE: push idx 0 with last=1, stay in OPEN.
- Transitions from BURST:
  - VALID: push idx+1.
  - DONE: push with last=1, go to OPEN.
  - Gaps (no-op cycles) are allowed and leave idx unchanged.
- Length limit:
  - A VALID beat at idx MAX_BEATS-1 is pushed with last=1 and abort=1.
  - `err_length` is set and the FSM goes to DROP.
  - A DONE beat at idx MAX_BEATS-1 is legal.
- Overflow, when a live beat arrives with no space:
  - The beat is dropped, `drop_cnt` increments, `err_overflow` is set, and the FSM goes to DROP.
  - `abort_pend` is set if the transaction had at least one beat pushed.
- DROP behaviour:
  - All live beats are dropped and counted.
  - DONE sets `done_seen`.
  - While `abort_pend` is set and space exists, push an abort entry: wdat=0, sub=0, idx = last pushed idx + 1 (saturating at MAX_BEATS-1), last=1, abort=1. This clears `abort_pend`.
  - Leave DROP for OPEN once `done_seen` is set and `abort_pend` is clear. The transition takes effect the cycle after the later of the two events.
  - Beats that arrive after DONE but before the exit are also dropped.
- An overflow on a transaction's first beat (from OPEN) drops it with no abort entry. The FSM goes to DROP with `done_seen` set if that beat was DONE.
- Space is defined as `count < DEPTH` OR a pop in the same cycle (`out_valid & out_ready`).
- `drop_cnt` saturates at 0xFFFF.
- The error flags clear only on reset.

## Timing
- Reset values: `out_valid`=0, all data outputs 0, both error flags 0, `drop_cnt`=0, FSM=OPEN, FIFO empty, `abort_pend`=0, `done_seen`=0.
- Latency: a beat sampled at cycle N is visible on the output at N+1 at the earliest. `out_valid` is a function of the registered count.
- Throughput: one push and one pop per cycle. With continuous `out_ready` there are never drops.
- Output handshake:
  - Data and flags are stable while `out_valid & !out_ready`.
  - `out_valid` never drops without a transfer.
- A push and pop in the same cycle while full succeeds; count is unchanged.
- A reset asserted mid-transaction or mid-DROP empties the FIFO and clears all state on the next edge. No abort entry is generated.

## Structure
- Shared package additions:
  - `HERO_BEAT_IDX_WIDTH`.
  - `hero_beat_t`, packed: wdat, sub, idx, last, abort; 36+7+IDXW+2 bits.
  - `HERO_COLLECT_STATE_E`: OPEN, BURST, DROP.
  - Width localparams, as is done for existing types.
- Sub-module `hero_sync_fifo`:
  - Parameterized by DEPTH and a generic type.
  - Ports: push/pop, full/empty, and a registered count.
  - Reused elsewhere.
- Top level: FSM, idx counter, abort/done flags, error and drop logic.

## Test plan
- Single transaction: VALID×3 then DONE, wdat 0x1..0x4, `out_ready`=1. Expect 4 beats at cycles N+1..N+4, idx 0..3, last only on idx 3, no errors.
- Single-beat DONE from OPEN, followed by a no-op and an idle-encoding beat. Expect 1 beat, idx 0, last=1. Encoding 3 produces nothing.
- Backpressure: `out_ready`=0, send DEPTH+2 live beats of one transaction (VALID…), then DONE, then raise `out_ready`. Expect:
  - DEPTH beats (idx 0..7), then an abort beat with idx 8, last=1, abort=1.
  - `err_overflow`=1 and `drop_cnt`=3.
- Over-length: 20 VALID beats, then DONE, with `out_ready`=1. Expect:
  - 16 beats; idx 15 has last=1 and abort=1.
  - `err_length`=1 and `drop_cnt`=5.
  - The next transaction starts at idx 0.
- Full with a simultaneous pop: keep the FIFO full with `out_ready` toggling each cycle while pushing every cycle. Expect no drops while pops coincide, and an ordered, gap-free idx sequence.
- Reset mid-BURST with 3 beats queued. Expect `out_valid`=0 the cycle after the reset edge, all outputs 0, and the next VALID starting at idx 0.
